// File: rtl/keypad_scan_debounce.sv
// 4x4 keypad front end: drives columns, synchronises rows, debounces press and
// release, and emits a one-cycle strobe with a stable keycode per accepted key.
`timescale 1ns/1ps
module keypad_scan_debounce #(
  parameter int SETTLE_CYCLES   = 64,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] keycode,
  output logic       keystrobe,
  output logic       keyheld
);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  function automatic logic one_low(input logic [3:0] r);
    logic [3:0] a;
    a = ~r;
    return (a != 4'h0) && ((a & (a - 4'd1)) == 4'h0);
  endfunction

  function automatic logic [1:0] low_index(input logic [3:0] r);
    case (r)
      4'b1101: return 2'd1;
      4'b1011: return 2'd2;
      4'b0111: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  logic [3:0]       row_p0, row_s;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       ci_q, ci_d, cand_q, cand_d;
  logic [3:0]       keycode_d, cand_pat;
  logic             keystrobe_d, keyheld_d;

  // Row synchronizer; rows idle high through the pull-ups
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      row_p0 <= 4'hF;
      row_s  <= 4'hF;
    end else begin
      row_p0 <= row;
      row_s  <= row_p0;
    end
  end

  assign col      = ~(4'b0001 << ci_q);
  assign cand_pat = ~(4'b0001 << cand_q);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= SCAN;
      cnt_q     <= '0;
      ci_q      <= 2'd0;
      cand_q    <= 2'd0;
      keycode   <= 4'h0;
      keystrobe <= 1'b0;
      keyheld   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ci_q      <= ci_d;
      cand_q    <= cand_d;
      keycode   <= keycode_d;
      keystrobe <= keystrobe_d;
      keyheld   <= keyheld_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CNT_ONE;
    ci_d        = ci_q;
    cand_d      = cand_q;
    keycode_d   = keycode;
    keystrobe_d = 1'b0;
    keyheld_d   = keyheld;
    case (state_q)
      SCAN: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d = '0;
          if (one_low(row_s)) begin
            cand_d  = low_index(row_s);
            state_d = DEBOUNCE;
          end else begin
            // No key or a multi-key chord: move on to the next column
            ci_d = ci_q + 2'd1;
          end
        end
      end
      DEBOUNCE: begin
        if (row_s != cand_pat) begin
          state_d = SCAN;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          keycode_d   = {cand_q, ci_q};
          keystrobe_d = 1'b1;
          keyheld_d   = 1'b1;
          state_d     = HELD;
          cnt_d       = '0;
        end
      end
      HELD: begin
        // Column stays frozen; only an unbroken all-high run counts as release
        if (row_s != 4'hF) begin
          cnt_d = '0;
        end else if (cnt_q == DEB_LAST) begin
          keyheld_d = 1'b0;
          ci_d      = ci_q + 2'd1;
          state_d   = SCAN;
          cnt_d     = '0;
        end
      end
      default: begin
        state_d = SCAN;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// Bench for keypad_scan_debounce: keypad matrix model, directed scenarios and
// a strobe scoreboard holding expected keycode and strobe cycle.
`timescale 1ns/1ps
module tb_keypad_scan_debounce;
  localparam int S = 4;
  localparam int D = 16;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic [15:0] keys = '0;
  logic [3:0]  row, col, keycode;
  logic        keystrobe, keyheld;
  int          cyc;

  typedef struct {
    int code;
    int at;
  } exp_t;
  exp_t sb[$];

  int tests = 0, fails = 0;
  int mon_tests = 0, mon_fails = 0;

  always #5 clock = ~clock;

  // Key at row r, column c pulls row r low while column c is driven low
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++) row[r] = ~|(keys[r*4 +: 4] & ~col);
  end

  keypad_scan_debounce #(.SETTLE_CYCLES(S), .DEBOUNCE_CYCLES(D), .CNT_W(8)) dut (
    .clock(clock), .reset_n(reset_n), .row(row), .col(col),
    .keycode(keycode), .keystrobe(keystrobe), .keyheld(keyheld)
  );

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  always @(negedge clock) begin
    exp_t e;
    if (reset_n && keystrobe) begin
      mon_tests++;
      if (sb.size() == 0) begin
        mon_fails++;
        $display("FAIL unexpected_strobe: keycode %0d at cycle %0d, no strobe expected", keycode, cyc);
      end else begin
        e = sb.pop_front();
        if (int'(keycode) != e.code) begin
          mon_fails++;
          $display("FAIL strobe_keycode: got %0d expected %0d", keycode, e.code);
        end
        mon_tests++;
        if (cyc != e.at) begin
          mon_fails++;
          $display("FAIL strobe_cycle: got %0d expected %0d", cyc, e.at);
        end
        mon_tests++;
        if (keyheld !== 1'b1) begin
          mon_fails++;
          $display("FAIL strobe_keyheld: got %0b expected 1", keyheld);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_col"}, int'(col), 14);
    chk({tag, "_keycode"}, int'(keycode), 0);
    chk({tag, "_keystrobe"}, int'(keystrobe), 0);
    chk({tag, "_keyheld"}, int'(keyheld), 0);
  endtask

  task automatic do_reset(input int n);
    reset_n = 1'b0;
    repeat (n) begin
      @(negedge clock);
      chk_reset_outputs("in_reset");
    end
    reset_n = 1'b1;
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clock);
  endtask

  task automatic chk_rotation(input string name, input int last);
    logic [3:0] e;
    for (int c = 0; c <= last; c++) begin
      wait_cyc(c);
      e = ~(4'b0001 << ((c / 4) % 4));
      chk(name, int'(col), int'(e));
    end
  endtask

  initial begin
    // Reset and idle scan
    #1;
    do_reset(10);
    chk_rotation("idle_col", 19);
    wait_cyc(40);

    // Clean press of row 1 / column 2
    keys = 16'h0040;
    do_reset(2);
    sb.push_back('{code: 6, at: 28});
    wait_cyc(40);
    chk("press_keyheld", int'(keyheld), 1);
    chk("press_col_frozen", int'(col), 4'b1011);
    chk("press_keycode", int'(keycode), 6);

    // Bounce on row 1, then stable press
    keys = '0;
    do_reset(2);
    sb.push_back('{code: 6, at: 68});
    for (int c = 0; c <= 60; c++) begin
      wait_cyc(c);
      keys[6] = (c >= 48) || (c >= 8 && ((c - 8) / 5) % 2 == 0);
    end

    // Long hold, glitchy release, re-press
    wait_cyc(500);
    chk("hold_keyheld", int'(keyheld), 1);
    chk("hold_col_frozen", int'(col), 4'b1011);
    wait_cyc(1068);
    keys[6] = 1'b0;
    wait_cyc(1073);
    keys[6] = 1'b1;
    wait_cyc(1076);
    keys[6] = 1'b0;
    wait_cyc(1093);
    chk("release_keyheld_before", int'(keyheld), 1);
    wait_cyc(1094);
    chk("release_keyheld_after", int'(keyheld), 0);
    chk("release_col_advance", int'(col), 4'b0111);
    sb.push_back('{code: 6, at: 1126});
    wait_cyc(1100);
    keys[6] = 1'b1;
    wait_cyc(1130);
    chk("repress_keyheld", int'(keyheld), 1);

    // Two rows low in column 1: treated as no key
    keys = 16'h0202;
    do_reset(2);
    chk_rotation("multi_col", 39);
    wait_cyc(100);
    chk("multi_keyheld", int'(keyheld), 0);

    // Asynchronous reset while a key is held
    keys = 16'h0040;
    do_reset(2);
    sb.push_back('{code: 6, at: 28});
    wait_cyc(40);
    chk("midheld_keyheld", int'(keyheld), 1);
    chk("midheld_keycode", int'(keycode), 6);
    #2;
    reset_n = 1'b0;
    #1;
    chk_reset_outputs("async_reset");
    keys = '0;
    @(negedge clock);
    reset_n = 1'b1;
    chk("restart_col0", int'(col), 4'b1110);
    wait_cyc(4);
    chk("restart_col1", int'(col), 4'b1101);
    wait_cyc(10);

    chk("scoreboard_drained", sb.size(), 0);
    tests += mon_tests;
    fails += mon_fails;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
